// File: rtl/s298_oracle_pkg.sv
// Shared widths, FSM state type and slot-offset helpers for the s298 query oracle.
package s298_oracle_pkg;

  localparam int unsigned NUM_PI = 3;
  localparam int unsigned NUM_PO = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRST  = 2'd1,
    APPLY = 2'd2,
    DONE  = 2'd3
  } state_e;

  // LSB of input vector k inside the packed query word
  function automatic int unsigned pi_lsb(input int unsigned k);
    return k * NUM_PI;
  endfunction

  // LSB of response slot k inside the packed response word
  function automatic int unsigned po_lsb(input int unsigned k);
    return k * NUM_PO;
  endfunction

endpackage

// File: rtl/s298_oracle_driver_if.sv
// Query/response handshake bundle between the host and the oracle driver.
interface s298_oracle_driver_if
  import s298_oracle_pkg::*;
#(
  parameter int unsigned MAXLEN = 16,
  parameter int unsigned LW     = 5
);

  logic                       q_valid;
  logic                       q_ready;
  logic [NUM_PI*MAXLEN-1:0]   q_vec;
  logic [LW-1:0]              q_len;
  logic                       r_valid;
  logic                       r_ready;
  logic [NUM_PO*MAXLEN-1:0]   r_resp;
  logic                       r_err;

  modport master (
    output q_valid, q_vec, q_len, r_ready,
    input  q_ready, r_valid, r_resp, r_err
  );

  modport slave (
    input  q_valid, q_vec, q_len, r_ready,
    output q_ready, r_valid, r_resp, r_err
  );

endinterface

// File: rtl/s298_oracle_driver_resp_capture.sv
// Response register: indexed write of one DUT output slot, synchronous clear, holds otherwise.
module s298_resp_capture
  import s298_oracle_pkg::*;
#(
  parameter int unsigned MAXLEN = 16,
  parameter int unsigned LW     = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr_i,
  input  logic                     we_i,
  input  logic [LW-1:0]            idx_i,
  input  logic [NUM_PO-1:0]        slot_i,
  output logic [NUM_PO*MAXLEN-1:0] resp_o
);

  localparam int unsigned RESP_W = NUM_PO * MAXLEN;

  logic [RESP_W-1:0] resp_q, resp_d;

  // Next response word: clear wins, then slot write, else hold
  always_comb begin
    resp_d = resp_q;
    if (clr_i) begin
      resp_d = '0;
    end else if (we_i && (32'(idx_i) < MAXLEN)) begin
      resp_d[po_lsb(32'(idx_i)) +: NUM_PO] = slot_i;
    end
  end

  // Response storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) resp_q <= '0;
    else        resp_q <= resp_d;
  end

  assign resp_o = resp_q;

endmodule

// File: rtl/s298_oracle_driver.sv
// Query oracle for s298: resets the core, plays a vector sequence, captures one output slot per cycle.
module s298_oracle_driver
  import s298_oracle_pkg::*;
#(
  parameter int unsigned MAXLEN  = 16,
  parameter int unsigned LW      = 5,
  parameter int unsigned RST_CYC = 2
) (
  input  logic                  CK,
  input  logic                  RN,
  s298_oracle_driver_if.slave   bus,
  output logic                  dut_rn,
  output logic [NUM_PI-1:0]     dut_in,
  input  logic [NUM_PO-1:0]     dut_out
);

  localparam int unsigned VW = NUM_PI * MAXLEN;
  localparam int unsigned RW = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;

  state_e            state_q, state_d;
  logic [LW-1:0]     cnt_q, cnt_d;
  logic [RW-1:0]     rcnt_q, rcnt_d;
  logic [LW-1:0]     len_q, len_d;
  logic [VW-1:0]     vec_q, vec_d;
  logic              err_q, err_d;
  logic              r_valid_q, r_valid_d;
  logic              q_ready_q, q_ready_d;
  logic              dut_rn_q, dut_rn_d;
  logic [NUM_PI-1:0] dut_in_q, dut_in_d;
  logic              cap_clr_c, cap_we_c;
  logic [LW-1:0]     cap_idx_c;

  // Next-state, counters and registered-output next values
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rcnt_d    = rcnt_q;
    len_d     = len_q;
    vec_d     = vec_q;
    err_d     = err_q;
    r_valid_d = 1'b0;
    dut_rn_d  = 1'b0;
    dut_in_d  = '0;
    cap_clr_c = 1'b0;
    cap_we_c  = 1'b0;
    cap_idx_c = '0;

    unique case (state_q)
      IDLE: begin
        if (bus.q_valid) begin
          vec_d     = bus.q_vec;
          len_d     = (32'(bus.q_len) > MAXLEN) ? LW'(MAXLEN) : bus.q_len;
          err_d     = (32'(bus.q_len) > MAXLEN);
          cap_clr_c = 1'b1;
          rcnt_d    = '0;
          state_d   = DRST;
        end
      end
      DRST: begin
        if (rcnt_q == RW'(RST_CYC - 1)) begin
          cnt_d = '0;
          if (len_q == '0) begin
            state_d = DONE;
          end else begin
            state_d  = APPLY;
            dut_rn_d = 1'b1;
            dut_in_d = vec_q[NUM_PI-1:0];
          end
        end else begin
          rcnt_d = rcnt_q + RW'(1);
        end
      end
      APPLY: begin
        // Slot c-1 is the core state after the edge that sampled vector c-1
        dut_rn_d = 1'b1;
        if (cnt_q != '0) begin
          cap_we_c  = 1'b1;
          cap_idx_c = cnt_q - LW'(1);
        end
        if (cnt_q == len_q) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + LW'(1);
          if (cnt_d < len_q) dut_in_d = vec_q[pi_lsb(32'(cnt_d)) +: NUM_PI];
        end
      end
      DONE: begin
        // Core stays out of reset only if it was actually run
        dut_rn_d  = dut_rn_q;
        r_valid_d = 1'b1;
        if (r_valid_q && bus.r_ready) begin
          r_valid_d = 1'b0;
          dut_rn_d  = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    q_ready_d = (state_d == IDLE);
  end

  // State and output registers
  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rcnt_q    <= '0;
      len_q     <= '0;
      vec_q     <= '0;
      err_q     <= 1'b0;
      r_valid_q <= 1'b0;
      q_ready_q <= 1'b1;
      dut_rn_q  <= 1'b0;
      dut_in_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rcnt_q    <= rcnt_d;
      len_q     <= len_d;
      vec_q     <= vec_d;
      err_q     <= err_d;
      r_valid_q <= r_valid_d;
      q_ready_q <= q_ready_d;
      dut_rn_q  <= dut_rn_d;
      dut_in_q  <= dut_in_d;
    end
  end

  s298_resp_capture #(
    .MAXLEN (MAXLEN),
    .LW     (LW)
  ) u_capture (
    .clk    (CK),
    .rst_n  (RN),
    .clr_i  (cap_clr_c),
    .we_i   (cap_we_c),
    .idx_i  (cap_idx_c),
    .slot_i (dut_out),
    .resp_o (bus.r_resp)
  );

  assign bus.q_ready = q_ready_q;
  assign bus.r_valid = r_valid_q;
  assign bus.r_err   = err_q;
  assign dut_rn      = dut_rn_q;
  assign dut_in      = dut_in_q;

endmodule

// File: tb/tb_s298_oracle_driver.sv
// Bench for s298_oracle_driver with an echo stub standing in for the s298 core.
module tb_s298_oracle_driver;

  localparam int unsigned MAXLEN  = 16;
  localparam int unsigned LW      = 5;
  localparam int unsigned RST_CYC = 2;

  logic       clk;
  logic       rn;
  logic       dut_rn;
  logic [2:0] dut_in;
  logic [5:0] dut_out;
  logic [2:0] stub_q;
  logic       rn_seen;

  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;

  s298_oracle_driver_if #(.MAXLEN(MAXLEN), .LW(LW)) bus ();

  s298_oracle_driver #(
    .MAXLEN  (MAXLEN),
    .LW      (LW),
    .RST_CYC (RST_CYC)
  ) dut (
    .CK      (clk),
    .RN      (rn),
    .bus     (bus),
    .dut_rn  (dut_rn),
    .dut_in  (dut_in),
    .dut_out (dut_out)
  );

  // Echo stub: registers dut_in, cleared while dut_rn is low
  always_ff @(posedge clk) stub_q <= dut_rn ? dut_in : 3'b000;
  assign dut_out = {3'b000, stub_q};

  always @(posedge clk) if (dut_rn === 1'b1) rn_seen = 1'b1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [4:0]  len;
    logic [47:0] vec;
    logic [95:0] resp;
    logic        err;
  } vec_t;

  typedef struct {
    logic [95:0] resp;
    logic        err;
    int unsigned lat;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[5];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Echo model: slot k holds vector k for k<len, zero beyond
  function automatic logic [95:0] model(input int unsigned len, input logic [47:0] vec);
    logic [95:0] r;
    int unsigned n;
    r = '0;
    n = (len > MAXLEN) ? MAXLEN : len;
    for (int k = 0; k < 16; k++) begin
      if (k < int'(n)) r[6*k +: 6] = {3'b000, vec[3*k +: 3]};
    end
    return r;
  endfunction

  function automatic int unsigned exp_lat(input int unsigned len);
    int unsigned n;
    n = (len > MAXLEN) ? MAXLEN : len;
    return (n == 0) ? RST_CYC + 1 : RST_CYC + n + 2;
  endfunction

  // One full query; hold>0 keeps r_ready low and pokes q_valid while the response waits
  task automatic run_query(input logic [4:0] len, input logic [47:0] vec,
                           input logic [95:0] exp_resp, input logic exp_err,
                           input int unsigned hold, input string nm);
    exp_t        e;
    int unsigned lat;
    @(negedge clk);
    chk({nm, " q_ready idle"}, 128'(bus.q_ready), 128'(1));
    bus.q_valid = 1'b1;
    bus.q_len   = len;
    bus.q_vec   = vec;
    e.resp = exp_resp;
    e.err  = exp_err;
    e.lat  = exp_lat(32'(len));
    sb.push_back(e);
    @(posedge clk);
    #1;
    bus.q_valid = 1'b0;
    chk({nm, " q_ready busy"}, 128'(bus.q_ready), 128'(0));
    lat = 0;
    while (!bus.r_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (sb.size() == 0) begin
      chk({nm, " scoreboard empty"}, 128'(0), 128'(1));
      return;
    end
    e = sb.pop_front();
    chk({nm, " latency"}, 128'(lat), 128'(e.lat));
    chk({nm, " r_resp"},  128'(bus.r_resp), 128'(e.resp));
    chk({nm, " r_err"},   128'(bus.r_err), 128'(e.err));
    for (int i = 0; i < int'(hold); i++) begin
      @(negedge clk);
      bus.q_valid = 1'b1;
      bus.q_len   = 5'd1;
      bus.q_vec   = 48'h7;
      chk({nm, " held r_resp"},  128'(bus.r_resp), 128'(e.resp));
      chk({nm, " held q_ready"}, 128'(bus.q_ready), 128'(0));
      chk({nm, " held r_valid"}, 128'(bus.r_valid), 128'(1));
    end
    @(negedge clk);
    bus.q_valid = 1'b0;
    bus.r_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.r_ready = 1'b0;
    chk({nm, " r_valid drop"}, 128'(bus.r_valid), 128'(0));
    chk({nm, " q_ready back"}, 128'(bus.q_ready), 128'(1));
    chk({nm, " dut_rn idle"},  128'(dut_rn), 128'(0));
  endtask

  initial begin
    logic [47:0] v;
    logic [4:0]  l;
    exp_t        drop;

    tbl[0].len = 5'd3;  tbl[0].vec = 48'h157;          tbl[0].resp = 96'h5087; tbl[0].err = 1'b0;
    tbl[1].len = 5'd1;  tbl[1].vec = 48'h6;            tbl[1].resp = 96'h6;    tbl[1].err = 1'b0;
    tbl[2].len = 5'd2;  tbl[2].vec = 48'hFE0;          tbl[2].resp = 96'h100;  tbl[2].err = 1'b0;
    tbl[3].len = 5'd16; tbl[3].vec = 48'hFFFF_FFFF_FFFF;
    tbl[3].resp = model(16, 48'hFFFF_FFFF_FFFF);       tbl[3].err = 1'b0;
    tbl[4].len = 5'd20; tbl[4].vec = 48'h1234_5678_9ABC;
    tbl[4].resp = model(16, 48'h1234_5678_9ABC);       tbl[4].err = 1'b1;

    rn          = 1'b0;
    rn_seen     = 1'b0;
    bus.q_valid = 1'b0;
    bus.q_len   = '0;
    bus.q_vec   = '0;
    bus.r_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset q_ready", 128'(bus.q_ready), 128'(1));
    chk("reset r_valid", 128'(bus.r_valid), 128'(0));
    chk("reset r_err",   128'(bus.r_err),   128'(0));
    chk("reset r_resp",  128'(bus.r_resp),  128'(0));
    chk("reset dut_rn",  128'(dut_rn),      128'(0));
    chk("reset dut_in",  128'(dut_in),      128'(0));
    rn = 1'b1;

    for (int i = 0; i < 5; i++)
      run_query(tbl[i].len, tbl[i].vec, tbl[i].resp, tbl[i].err, 0, $sformatf("tbl%0d", i));

    // Error flag clears on the next accepted query
    run_query(5'd1, 48'h3, 96'h3, 1'b0, 0, "err_clear");

    // Zero-length query never releases the core from reset
    @(negedge clk);
    rn_seen = 1'b0;
    run_query(5'd0, 48'hABC, 96'h0, 1'b0, 0, "len0");
    chk("len0 dut_rn never high", 128'(rn_seen), 128'(0));

    // Back-pressure for 10 cycles
    run_query(5'd4, 48'hD2B, model(4, 48'hD2B), 1'b0, 10, "backpressure");

    // Reset mid-APPLY at c=2 of 5
    @(negedge clk);
    bus.q_valid = 1'b1;
    bus.q_len   = 5'd5;
    bus.q_vec   = 48'h7FFF;
    drop.resp = model(5, 48'h7FFF);
    drop.err  = 1'b0;
    drop.lat  = exp_lat(5);
    sb.push_back(drop);
    @(posedge clk);
    #1;
    bus.q_valid = 1'b0;
    repeat (RST_CYC + 2) @(posedge clk);
    #1;
    chk("midreset dut_rn before", 128'(dut_rn), 128'(1));
    chk("midreset dut_in before", 128'(dut_in), 128'(3'b111));
    rn = 1'b0;
    // Aborted query yields no response
    void'(sb.pop_back());
    #1;
    chk("midreset q_ready", 128'(bus.q_ready), 128'(1));
    chk("midreset r_valid", 128'(bus.r_valid), 128'(0));
    chk("midreset r_err",   128'(bus.r_err),   128'(0));
    chk("midreset r_resp",  128'(bus.r_resp),  128'(0));
    chk("midreset dut_rn",  128'(dut_rn),      128'(0));
    chk("midreset dut_in",  128'(dut_in),      128'(0));
    @(negedge clk);
    rn = 1'b1;
    run_query(5'd5, 48'h5A5A, model(5, 48'h5A5A), 1'b0, 0, "after_reset");

    // Random queries against the echo model
    for (int i = 0; i < 20; i++) begin
      l = 5'($urandom_range(0, 18));
      v = {16'($urandom), 32'($urandom)};
      run_query(l, v, model(32'(l), v), (32'(l) > MAXLEN), 0, $sformatf("rand%0d", i));
    end

    chk("scoreboard drained", 128'(sb.size()), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
